// File: rtl/monopulse_gen.sv
// Single-shot pulse generator: synchronised start, selectable edge, N-cycle pulse, done strobe, saturating count.
// Pulse rises SYNC_STAGES edges after start is first sampled; there is no backpressure, so edges are dropped or retrigger.
module monopulse_gen #(
    parameter int unsigned N           = 5,
    parameter int unsigned EDGE        = 0,
    parameter int unsigned RETRIG      = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        pulse,
    output logic        done,
    output logic [15:0] pulse_cnt
);

    localparam logic [0:0]  IDLE   = 1'b0;
    localparam logic [0:0]  ACTIVE = 1'b1;
    localparam logic [15:0] RELOAD = 16'(N - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q;
    logic [0:0]             state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [15:0]            pcnt_q, pcnt_d;
    logic                   s, rise, fall, trig, accept;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = start;
    end

    always_comb begin
        case (EDGE)
            0:       trig = rise;
            1:       trig = fall;
            default: trig = rise | fall;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        if (state_q == IDLE) begin
            if (trig) begin
                state_d = ACTIVE;
                cnt_d   = RELOAD;
                accept  = 1'b1;
            end
        end else begin
            // A retrigger wins over the end of the pulse, so the last cycle can still extend it.
            if ((RETRIG == 1) && trig) begin
                cnt_d  = RELOAD;
                accept = 1'b1;
            end else if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (accept && (pcnt_q != CNT_MAX)) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_q  <= '0;
            s_d_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            done_q  <= 1'b0;
            pcnt_q  <= 16'd0;
        end else begin
            sync_q  <= sync_d;
            s_d_q   <= s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign pulse     = (state_q == ACTIVE);
    assign done      = done_q;
    assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_monopulse_gen.sv
// Scoreboard bench for monopulse_gen: four configurations, expected pulses queued by stimulus, checked at each done.
// Instances: 0 rising/no-retrig, 1 both/retrig, 2 both/no-retrig, 3 N=1 both/retrig (saturation).
module tb_monopulse_gen;

    typedef struct {
        int rise;
        int width;
        int cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a;
    logic        start_d;
    logic [3:0]  pulse_w;
    logic [3:0]  done_w;
    logic [15:0] cnt_w [4];

    exp_t exp_q [4][$];
    exp_t mon_e;
    int   ecnt [4];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   prev_p [4];
    bit   prev_d [4];
    int   rise_c [4];
    int   wid    [4];
    int   k;

    always #2 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    monopulse_gen #(.N(5), .EDGE(0), .RETRIG(0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .pulse(pulse_w[0]), .done(done_w[0]), .pulse_cnt(cnt_w[0]));
    monopulse_gen #(.N(5), .EDGE(2), .RETRIG(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .pulse(pulse_w[1]), .done(done_w[1]), .pulse_cnt(cnt_w[1]));
    monopulse_gen #(.N(5), .EDGE(2), .RETRIG(0), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .pulse(pulse_w[2]), .done(done_w[2]), .pulse_cnt(cnt_w[2]));
    monopulse_gen #(.N(1), .EDGE(2), .RETRIG(1), .SYNC_STAGES(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_d),
        .pulse(pulse_w[3]), .done(done_w[3]), .pulse_cnt(cnt_w[3]));

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // rise is the edge count at which pulse is expected high for the first time.
    task automatic expect_pulse(input int i, input int rise, input int width, input int incs);
        exp_t e;
        ecnt[i] = ecnt[i] + incs;
        if (ecnt[i] > 65535) ecnt[i] = 65535;
        e.rise  = rise;
        e.width = width;
        e.cnt   = ecnt[i];
        exp_q[i].push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_pending%0d", tag, i), exp_q[i].size(), 0);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pulse_w[i] && !prev_p[i]) begin
                rise_c[i] = cyc;
                wid[i]    = 0;
            end
            if (pulse_w[i]) wid[i] = wid[i] + 1;
            if (done_w[i]) begin
                check($sformatf("done_single%0d", i), int'(prev_d[i]), 0);
                check($sformatf("done_at_fall%0d", i), int'(prev_p[i] && !pulse_w[i]), 1);
                check($sformatf("done_expected%0d", i), int'(exp_q[i].size() > 0), 1);
                if (exp_q[i].size() > 0) begin
                    mon_e = exp_q[i].pop_front();
                    check($sformatf("rise%0d", i), rise_c[i], mon_e.rise);
                    check($sformatf("width%0d", i), wid[i], mon_e.width);
                    check($sformatf("pulse_cnt%0d", i), int'(cnt_w[i]), mon_e.cnt);
                end
            end
            prev_p[i] = pulse_w[i];
            prev_d[i] = done_w[i];
        end
    end

    initial begin
        rst_n   = 1'b1;
        start_a = 1'b0;
        start_d = 1'b0;
        for (int i = 0; i < 4; i++) ecnt[i] = 0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_pulse%0d", i), int'(pulse_w[i]), 0);
            check($sformatf("rst_done%0d", i), int'(done_w[i]), 0);
            check($sformatf("rst_cnt%0d", i), int'(cnt_w[i]), 0);
        end
        rst_n = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("idle_pulse%0d", i), int'(pulse_w[i]), 0);
            check($sformatf("idle_cnt%0d", i), int'(cnt_w[i]), 0);
        end

        // Basic rising then falling edge.
        start_a = 1'b1;
        k = cyc;
        expect_pulse(0, k + 3, 5, 1);
        expect_pulse(1, k + 3, 5, 1);
        expect_pulse(2, k + 3, 5, 1);
        tick(30);
        drain("rise");
        start_a = 1'b0;
        k = cyc;
        expect_pulse(1, k + 3, 5, 1);
        expect_pulse(2, k + 3, 5, 1);
        tick(30);
        drain("fall");

        // Second edge 3 cycles after the first.
        start_a = 1'b1;
        k = cyc;
        tick(3);
        start_a = 1'b0;
        expect_pulse(0, k + 3, 5, 1);
        expect_pulse(1, k + 3, 8, 2);
        expect_pulse(2, k + 3, 5, 1);
        tick(30);
        drain("retrig");

        // Second edge lands on the last pulse cycle.
        start_a = 1'b1;
        k = cyc;
        tick(5);
        start_a = 1'b0;
        expect_pulse(0, k + 3, 5, 1);
        expect_pulse(1, k + 3, 10, 2);
        expect_pulse(2, k + 3, 5, 1);
        tick(30);
        drain("lastcyc");

        // Reset during the third pulse cycle; start stays high across release.
        start_a = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst_pulse%0d", i), int'(pulse_w[i]), 0);
            check($sformatf("midrst_cnt%0d", i), int'(cnt_w[i]), 0);
            check($sformatf("midrst_done%0d", i), int'(done_w[i]), 0);
        end
        rst_n = 1'b0;
        k = cyc;
        for (int i = 0; i < 4; i++) ecnt[i] = 0;
        expect_pulse(0, k + 3, 5, 1);
        expect_pulse(1, k + 3, 5, 1);
        expect_pulse(2, k + 3, 5, 1);
        tick(30);
        drain("relrst");

        // Periodic toggling every 30 cycles.
        repeat (333) begin
            start_a = ~start_a;
            k = cyc;
            if (start_a) expect_pulse(0, k + 3, 5, 1);
            expect_pulse(1, k + 3, 5, 1);
            expect_pulse(2, k + 3, 5, 1);
            tick(30);
        end
        tick(10);
        drain("periodic");
        check("periodic_cnt0", int'(cnt_w[0]), 167);
        check("periodic_cnt1", int'(cnt_w[1]), 334);
        check("periodic_cnt2", int'(cnt_w[2]), 334);

        // Saturation: one accepted edge per cycle, then one more isolated pulse.
        k = cyc;
        expect_pulse(3, k + 3, 65540, 65540);
        for (int j = 0; j < 65540; j++) begin
            start_d = ~start_d;
            tick(1);
        end
        tick(10);
        start_d = ~start_d;
        k = cyc;
        expect_pulse(3, k + 3, 1, 1);
        tick(10);
        drain("sat");
        check("sat_cnt3", int'(cnt_w[3]), 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
